// File: rtl/apb_mem_slave.sv
// Parametrised APB register-file slave with wait states and PSLVERR on out-of-range word addresses.
// Optional byte strobes are enabled by defining APB_MEM_SLAVE_PSTRB_EN.
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_MEM_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    wr_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    ready_s;
    logic                    err_s;
    logic                    commit_s;
    logic [IDX_W-1:0]        idx_s;
    logic [NBYTES-1:0]       strb_s;

    // Byte-lane merge of new write data into an existing word
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

`ifdef APB_MEM_SLAVE_PSTRB_EN
    assign strb_s = PSTRB;
`else
    assign strb_s = '1;
`endif

    assign idx_s = addr_r[IDX_W-1:0];

    // Setup/access state machine with captured address, direction and wait counter
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
            wr_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A lone PENABLE without a setup cycle is ignored here
                    if (PSEL && !PENABLE) begin
                        addr_r  <= PADDR;
                        wr_r    <= PWRITE;
                        cnt_r   <= CNT_W'(WAIT_STATES);
                        state_r <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else if (PENABLE) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory array: cleared on reset, written only at a clean write completion
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (commit_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], PWDATA, strb_s);
        end
    end

    // Response decode from registered state
    always_comb begin
        ready_s  = (state_r == ST_ACCESS) && (cnt_r == 4'd0);
        err_s    = ({1'b0, addr_r} >= DEPTH_L);
        commit_s = ready_s && PSEL && PENABLE && wr_r && !err_s;
        PREADY   = ready_s;
        PSLVERR  = ready_s && err_s;
        if (ready_s && !wr_r && !err_s) begin
            PRDATA = mem_r[idx_s];
        end else begin
            PRDATA = '0;
        end
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- Parametrised APB slave: register-file memory with configurable data width, address width, depth and wait states.
- Adds PSLVERR for out-of-range addresses, plus a clocked setup/access state machine.
- Sits on the APB bus behind the master/decoder as the generic replacement for the fixed 8-bit, 64-entry, zero-wait slaves.

Parameters:
DATA_WIDTH, 32, width of PWDATA/PRDATA and of each memory word (multiple of 8)
ADDR_WIDTH, 8, width of PADDR; PADDR is a word index
DEPTH, 64, number of memory words; must satisfy DEPTH <= 2**ADDR_WIDTH
WAIT_STATES, 0, access-phase cycles with PREADY=0 before completion (0..15)

Ports:
PCLK  input  1  bus clock; all state updates on its rising edge
PRESETn  input  1  reset; asynchronous, active-low
PSEL  input  1  slave select
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1=write, 0=read
PADDR  input  ADDR_WIDTH  word address
PWDATA  input  DATA_WIDTH  write data
PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1 on a read
PREADY  output  1  transfer-complete handshake
PSLVERR  output  1  error response; valid only while PREADY=1

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE, wait counter=0, captured addr/dir=0, all memory words=0. PREADY=0, PSLVERR=0, PRDATA=0 immediately and for as long as reset is held.
- States: IDLE, ACCESS.
- IDLE, PSEL=1 and PENABLE=0 (setup cycle):
  - capture PADDR and PWRITE into addr_q/wr_q
  - load counter with WAIT_STATES
  - go to ACCESS
- IDLE, PSEL=1 and PENABLE=1 with no preceding setup: protocol violation; ignored, stay IDLE, PREADY=0.
- ACCESS:
  - PREADY = (counter==0), combinational from registered state.
  - While counter!=0 and PSEL=1, counter decrements each cycle.
  - Completion cycle = ACCESS with PSEL=1, PENABLE=1, PREADY=1. At its closing edge:
    - write: mem[addr_q] <= PWDATA (PWDATA sampled at this edge)
    - state -> IDLE
- ACCESS, PSEL=0 before completion (master abort): state -> IDLE, no write, no response.
- Latency: WAIT_STATES=N gives PREADY high in the (N+1)th access-phase cycle. N=0 means a two-cycle transfer.
- Back-to-back transfers: every transfer passes through IDLE/setup; no pipelining of a setup cycle into a completion cycle.
- Range check: err = (addr_q >= DEPTH).
  - PSLVERR = PREADY & err; 0 at all other times.
  - Errored write: no memory update.
  - Errored read: PRDATA=0.
- PRDATA = mem[addr_q] when PREADY & !wr_q & !err; otherwise all zeros.
- PADDR/PWRITE changes during ACCESS are ignored: addr_q and wr_q are held.
- Reset mid-transfer: immediate return to IDLE, PREADY drops the same cycle, and an uncompleted write is lost.
- DEPTH not a power of two: indices DEPTH..2**ADDR_WIDTH-1 all error; no aliasing.

Optional Feature:
- Macro APB_MEM_SLAVE_PSTRB_EN.
- Defined:
  - adds input PSTRB, width DATA_WIDTH/8; byte lane i is written only if PSTRB[i]=1, sampled at the completion edge.
  - PSTRB all zeros on a write: completes with PREADY and PSLVERR=0, memory unchanged.
  - Reads ignore PSTRB.
- Undefined: no PSTRB port; every write updates all bytes.

Test Plan:
1. Reset, then WAIT_STATES=0: write 0xDEADBEEF to addr 5, read addr 5 -> PREADY on the 2nd cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
2. WAIT_STATES=3: read addr 0 after reset -> PREADY low for 3 access cycles, high on the 4th, PRDATA=0x00000000.
3. DEPTH=64: write 0x12345678 to addr 64, then read addr 64 -> both complete with PSLVERR=1, read PRDATA=0; a read of addr 0 is still 0.
4. WAIT_STATES=2: write 0xA5A5A5A5 to addr 10, drop PSEL after 1 access cycle (abort); then read addr 10 -> PRDATA=0, no PREADY seen during the abort.
5. Write 0xFFFFFFFF to addr 7; assert PRESETn=0 mid-access of a second write to addr 7; release and read addr 7 -> PREADY=0 during reset, PRDATA=0 (memory cleared).
6. With APB_MEM_SLAVE_PSTRB_EN: write 0x11223344 to addr 2 with PSTRB=4'b1111, then 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.
